// File: rtl/iiitb_cg_pkg.sv
// Shared definitions for the clock-gating controller: FSM state encoding and
// counter widths sized to the legal ranges of IDLE_CYCLES and WAKE_CYCLES.
package iiitb_cg_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IDLE_WAIT = 2'd1,
    SLEEP     = 2'd2,
    WAKE      = 2'd3
  } cg_state_e;

  localparam int IDLE_CNT_W = 8;  // IDLE_CYCLES legal 1..255
  localparam int WAKE_CNT_W = 4;  // WAKE_CYCLES legal 1..15
  localparam int STATS_W    = 8;

endpackage

// File: rtl/iiitb_icg_cell.sv
// Glitch-free clock gate: enable captured on the falling edge of clk, then
// ANDed with clk so the enable only changes while clk is low.
module iiitb_icg_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic gclk
);

  logic en_q;

  // NOTE: reset forces the enable high so the gated domain runs during and
  // immediately after reset, whatever state the gate was left in.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) en_q <= 1'b1;
    else     en_q <= en;
  end

  assign gclk = clk & en_q;

endmodule

// File: rtl/iiitb_cg_ctrl.sv
// Idle-detect clock-gating controller with RUN/IDLE_WAIT/SLEEP/WAKE FSM.
// Define IIITB_CG_STATS_EN to add the saturating sleep_cnt output.
module iiitb_cg_ctrl
  import iiitb_cg_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic act,
  input  logic busy,
  output logic ready,
  output logic clk_en,
  output logic cgclk,
  output logic sleeping
`ifdef IIITB_CG_STATS_EN
  ,
  output logic [STATS_W-1:0] sleep_cnt
`endif
);

  localparam logic [IDLE_CNT_W-1:0] IDLE_LIMIT = IDLE_CYCLES[IDLE_CNT_W-1:0];
  localparam logic [WAKE_CNT_W-1:0] WAKE_LIMIT = WAKE_CYCLES[WAKE_CNT_W-1:0];

  cg_state_e             state_q, state_d;
  logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic                  ready_q, ready_d;
  logic                  clk_en_q, clk_en_d;
  logic                  sleeping_q, sleeping_d;

  // State register; outputs are registered from the next state so they change
  // on the same edge as the state and carry no decode glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      ready_q    <= 1'b1;
      clk_en_q   <= 1'b1;
      sleeping_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      ready_q    <= ready_d;
      clk_en_q   <= clk_en_d;
      sleeping_q <= sleeping_d;
    end
  end

  // Counters only advance while below their limit, so they saturate by design.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      RUN: begin
        idle_cnt_d = '0;
        if (!act && !busy) begin
          state_d    = IDLE_WAIT;
          idle_cnt_d = IDLE_CNT_W'(1);
        end
      end
      IDLE_WAIT: begin
        if (act || busy) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end else if (idle_cnt_q >= IDLE_LIMIT) begin
          state_d    = SLEEP;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      SLEEP: begin
        if (act) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        if (wake_cnt_q >= WAKE_LIMIT) begin
          state_d    = RUN;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    ready_d    = 1'b1;
    clk_en_d   = 1'b1;
    sleeping_d = 1'b0;
    unique case (state_d)
      SLEEP: begin
        ready_d    = 1'b0;
        clk_en_d   = 1'b0;
        sleeping_d = 1'b1;
      end
      WAKE:    ready_d = 1'b0;
      default: ;
    endcase
  end

  assign ready    = ready_q;
  assign clk_en   = clk_en_q;
  assign sleeping = sleeping_q;

  iiitb_icg_cell u_icg (
    .clk  (clk),
    .rst  (rst),
    .en   (clk_en_q),
    .gclk (cgclk)
  );

`ifdef IIITB_CG_STATS_EN
  logic [STATS_W-1:0] sleep_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sleep_cnt_q <= '0;
    end else if (state_q != SLEEP && state_d == SLEEP && sleep_cnt_q != '1) begin
      sleep_cnt_q <= sleep_cnt_q + 1'b1;
    end
  end

  assign sleep_cnt = sleep_cnt_q;
`endif

endmodule

// File: doc/iiitb_cg_ctrl.md
IIITB_CG_CTRL -- requirements
Module: iiitb_cg_ctrl

Interface
REQ-001 SHALL have parameter IDLE_CYCLES, default 8, consecutive idle cycles before gating (legal 1..255).
REQ-002 SHALL have parameter WAKE_CYCLES, default 2, clock-enabled cycles before ready reasserts (legal 1..15).
REQ-003 SHALL have port clk, input, 1, the single free-running clock; all state uses clk only.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port act, input, 1, activity request from the client logic (work pending).
REQ-006 SHALL have port busy, input, 1, the gated domain is still draining; it blocks sleep entry.
REQ-007 SHALL have port ready, output, 1, the gated domain is clocked and may accept work.
REQ-008 SHALL have port clk_en, output, 1, the registered enable driven into the gate cell.
REQ-009 SHALL have port cgclk, output, 1, the gated clock.
REQ-010 SHALL have port sleeping, output, 1, high exactly while in state SLEEP.

Function
REQ-011 SHALL implement the FSM states RUN, IDLE_WAIT, SLEEP and WAKE.
REQ-012 RUN: clk_en=1 and ready=1; on a cycle with act=0 and busy=0, go to IDLE_WAIT and load the idle counter with 1.
REQ-013 IDLE_WAIT: clk_en=1 and ready=1; on act=1 or busy=1, return to RUN the next cycle and clear the counter; otherwise increment the counter.
REQ-014 IDLE_WAIT: when the counter equals IDLE_CYCLES with act=0 and busy=0, go to SLEEP and drop clk_en.
REQ-015 SLEEP: clk_en=0, ready=0 and sleeping=1; busy is ignored; on act=1, go to WAKE the next cycle.
REQ-016 WAKE: clk_en=1 and ready=0; count WAKE_CYCLES cycles, then go to RUN with ready=1; act is ignored during WAKE.
REQ-017 An act=1 that arrives in the same cycle as the terminal idle count SHALL win: the FSM returns to RUN and never enters SLEEP.
REQ-018 The client SHALL hold act high until it samples ready=1; ready SHALL rise exactly WAKE_CYCLES+1 cycles after act is sampled in SLEEP.
REQ-019 cgclk SHALL equal clk AND a latched copy of clk_en that is captured on the falling edge of clk.
REQ-020 cgclk SHALL never glitch, and a clk_en change SHALL take effect from the next rising edge of clk.
REQ-021 Counters SHALL be sized to their parameter, saturate, and never wrap.

Reset
REQ-022 rst SHALL force state RUN, clear all counters, set ready=1, clk_en=1 and sleeping=0, and reset the latched enable to 1.
REQ-023 Reset asserted mid-SLEEP or mid-WAKE SHALL restore a running cgclk within one clk period of rst being released.

Configuration
REQ-024 With macro IIITB_CG_STATS_EN defined, the block SHALL add output sleep_cnt, 8 bits, counting SLEEP entries; it saturates at 255 and is cleared by rst.
REQ-025 Without IIITB_CG_STATS_EN, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 Shared package iiitb_cg_pkg SHALL hold the state encoding (RUN=0, IDLE_WAIT=1, SLEEP=2, WAKE=3) and the counter-width constants.
REQ-027 The gate SHALL be a sub-module iiitb_icg_cell (ports clk, rst, en, gclk), built from a negative-edge enable flop plus an AND gate.
REQ-028 The FSM and counters SHALL live in iiitb_cg_ctrl.

Verification
REQ-029 Reset, then act=0 and busy=0 for 8 cycles -> SLEEP entered at cycle 9; clk_en=0, sleeping=1, cgclk held low.
REQ-030 In SLEEP, pulse act high and hold it -> cgclk resumes at the next rising edge; ready=1 exactly 3 cycles after act is sampled (WAKE_CYCLES=2).
REQ-031 Idle for 7 cycles, then busy=1 for 1 cycle, then idle again -> no SLEEP until 8 fresh idle cycles have elapsed.
REQ-032 act=1 on the 8th idle cycle -> state RUN, sleeping never asserts, and cgclk is continuous.
REQ-033 rst asserted during WAKE -> ready=1 and clk_en=1 immediately; cgclk toggling on the first clk edge after release.
REQ-034 With IIITB_CG_STATS_EN defined, run 300 sleep/wake cycles -> sleep_cnt reads 255 and holds.
